// File: rtl/arb_class_pkg.sv
// Shared definitions for the class arbiter: FSM state encodings and word field positions.
package arb_class_pkg;

    localparam int WORD_W    = 10;
    localparam int CLASS_BIT = 9;
    localparam int DEST_BIT  = 8;
    localparam int DATA_LSB  = 0;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_class_elig.sv
// Per-class eligibility: a class may be granted when its FIFO has a head word
// and the destination that head targets is not almost full.
module arb_class_elig (
    input  logic       empty,
    input  logic       head_dest,
    input  logic [1:0] out_afull,
    output logic       elig
);

    assign elig = !empty && !out_afull[head_dest];

endmodule

// File: rtl/arbiter_class.sv
// Weighted round-robin arbiter between the class-0 and class-1 FIFOs, feeding the dest FIFOs.
// Optional grant statistics are built when ARB_CLASS_STATS_EN is defined.
module arbiter_class #(
    parameter int DATA_W  = 8,
    parameter int WORD_W  = DATA_W + 2,
    parameter int WEIGHT1 = 3
`ifdef ARB_CLASS_STATS_EN
    ,
    parameter int STAT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arb_en,
    input  logic              fifo0_empty,
    input  logic              fifo1_empty,
    input  logic [WORD_W-1:0] fifo0_data,
    input  logic [WORD_W-1:0] fifo1_data,
    input  logic [1:0]        out_afull,
    output logic              pop0,
    output logic              pop1,
    output logic [WORD_W-1:0] dataout,
    output logic [1:0]        push,
    output logic              valid_out,
    output logic [1:0]        arb_state
`ifdef ARB_CLASS_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [STAT_W-1:0] grant_cnt0,
    output logic [STAT_W-1:0] grant_cnt1
`endif
);
    import arb_class_pkg::*;

    localparam logic [2:0] W1 = 3'(WEIGHT1);

    arb_state_t  state_q, state_d;
    logic [2:0]  credit_q;
    logic        elig0, elig1;
    logic        gnt0_p0, gnt1_p0;
    logic [WORD_W-1:0] sel_word_p0;

    function automatic logic [2:0] credit_inc(input logic [2:0] c);
        return (c >= W1) ? W1 : c + 3'd1;
    endfunction

    arb_class_elig u_elig0 (
        .empty     (fifo0_empty),
        .head_dest (fifo0_data[DEST_BIT]),
        .out_afull (out_afull),
        .elig      (elig0)
    );

    arb_class_elig u_elig1 (
        .empty     (fifo1_empty),
        .head_dest (fifo1_data[DEST_BIT]),
        .out_afull (out_afull),
        .elig      (elig1)
    );

    // Stage p0: state transition and grant decision
    always_comb begin
        state_d = state_q;
        gnt0_p0 = 1'b0;
        gnt1_p0 = 1'b0;
        case (state_q)
            ST_INIT: state_d = ST_IDLE;
            ST_IDLE: begin
                if (arb_en && (elig0 || elig1))
                    state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (!arb_en || !(elig0 || elig1)) begin
                    state_d = ST_IDLE;
                end else if (elig1 && (credit_q < W1 || !elig0)) begin
                    gnt1_p0 = 1'b1;
                end else begin
                    gnt0_p0 = 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    assign sel_word_p0 = gnt1_p0 ? fifo1_data : fifo0_data;
    assign pop0        = gnt0_p0 && !reset;
    assign pop1        = gnt1_p0 && !reset;
    assign arb_state   = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_INIT;
            credit_q <= 3'd0;
        end else begin
            state_q <= state_d;
            if (gnt1_p0)
                credit_q <= credit_inc(credit_q);
            else if (gnt0_p0)
                credit_q <= 3'd0;
        end
    end

    // Stage p1: registered word and one-hot push toward the dest FIFOs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dataout   <= '0;
            push      <= 2'b00;
            valid_out <= 1'b0;
        end else begin
            valid_out <= gnt0_p0 || gnt1_p0;
            if (gnt0_p0 || gnt1_p0) begin
                dataout <= sel_word_p0;
                push    <= {sel_word_p0[DEST_BIT], !sel_word_p0[DEST_BIT]};
            end else begin
                push    <= 2'b00;
            end
        end
    end

`ifdef ARB_CLASS_STATS_EN
    // Clear takes priority over a same-cycle pop; counters wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (stats_clr) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (gnt0_p0)
                grant_cnt0 <= grant_cnt0 + 1'b1;
            if (gnt1_p0)
                grant_cnt1 <= grant_cnt1 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_arbiter_class.sv
// Scoreboard bench for arbiter_class: bench-side FIFO queues feed the DUT, expected words
// are queued in hand-derived grant order and checked by a negedge monitor on valid_out.
module tb_arbiter_class;

    logic        clk = 1'b0;
    logic        reset;
    logic        arb_en;
    logic        fifo0_empty, fifo1_empty;
    logic [9:0]  fifo0_data, fifo1_data;
    logic [1:0]  out_afull;
    logic        pop0, pop1;
    logic [9:0]  dataout;
    logic [1:0]  push;
    logic        valid_out;
    logic [1:0]  arb_state;
`ifdef ARB_CLASS_STATS_EN
    logic        stats_clr;
    logic [15:0] grant_cnt0, grant_cnt1;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic [9:0] exp_q[$];
    logic samp0 = 1'b0;
    logic samp1 = 1'b0;

    arbiter_class dut (
        .clk         (clk),
        .reset       (reset),
        .arb_en      (arb_en),
        .fifo0_empty (fifo0_empty),
        .fifo1_empty (fifo1_empty),
        .fifo0_data  (fifo0_data),
        .fifo1_data  (fifo1_data),
        .out_afull   (out_afull),
        .pop0        (pop0),
        .pop1        (pop1),
        .dataout     (dataout),
        .push        (push),
        .valid_out   (valid_out),
        .arb_state   (arb_state)
`ifdef ARB_CLASS_STATS_EN
        ,
        .stats_clr   (stats_clr),
        .grant_cnt0  (grant_cnt0),
        .grant_cnt1  (grant_cnt1)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic refresh();
        fifo0_empty = (q0.size() == 0);
        fifo1_empty = (q1.size() == 0);
        fifo0_data  = fifo0_empty ? 10'h3FF : q0[0];
        fifo1_data  = fifo1_empty ? 10'h3FF : q1[0];
    endtask

    // Pops sampled mid-cycle are applied to the bench FIFOs just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (samp0 && q0.size() > 0) q0.delete(0);
        if (samp1 && q1.size() > 0) q1.delete(0);
        refresh();
    endtask

    // ord lists the hand-computed winning class per grant, e.g. "1110".
    task automatic sched(input string ord);
        logic [9:0] c0[$];
        logic [9:0] c1[$];
        c0 = q0;
        c1 = q1;
        for (int i = 0; i < ord.len(); i++) begin
            if (ord[i] == "1") exp_q.push_back(c1.pop_front());
            else               exp_q.push_back(c0.pop_front());
        end
    endtask

    task automatic drain(input string name, input int limit);
        for (int i = 0; i < limit && (q0.size() > 0 || q1.size() > 0); i++)
            tick();
        if (q0.size() > 0 || q1.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout: q0=%0d q1=%0d words left, expected 0", name, q0.size(), q1.size());
        end
        tick();
        tick();
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        logic [9:0] w;
        samp0 = pop0;
        samp1 = pop1;
        if (valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_push: dataout=%h push=%b, expected no push", dataout, push);
            end else begin
                w = exp_q.pop_front();
                check("dataout", dataout, w);
                check("push", push, w[8] ? 2'b10 : 2'b01);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        arb_en    = 1'b1;
        out_afull = 2'b00;
`ifdef ARB_CLASS_STATS_EN
        stats_clr = 1'b0;
`endif
        refresh();

        // Reset then idle
        #12;
        check("rst_push", push, 2'b00);
        check("rst_valid", valid_out, 1'b0);
        check("rst_dataout", dataout, 10'h000);
        check("rst_state", arb_state, 2'd0);
        check("rst_pops", {pop1, pop0}, 2'b00);
        @(posedge clk);
        #1 reset = 1'b0;
        check("init_state", arb_state, 2'd0);
        tick();
        check("idle_state", arb_state, 2'd1);
        tick();
        check("idle_stay", arb_state, 2'd1);
        check("idle_push", push, 2'b00);
        check("idle_dataout", dataout, 10'h000);

        // WRR weighting with WEIGHT1=3
        for (int i = 0; i < 8; i++) begin
            q1.push_back(10'h200 | (10'(i & 1) << 8) | 10'(8'h10 + i));
            q0.push_back((10'(i & 1) << 8) | 10'(8'h80 + i));
        end
        sched("1110111011000000");
        refresh();
        drain("wrr", 60);

        // Backpressure on dest 1
        q1 = '{10'h301, 10'h302};
        q0 = '{10'h005};
        out_afull = 2'b10;
        sched("0");
        refresh();
        for (int i = 0; i < 4; i++) tick();
        check("bp_pop1", pop1, 1'b0);
        check("bp_state", arb_state, 2'd1);
        check("bp_q1_held", q1.size(), 2);
        out_afull = 2'b00;
        sched("11");
        refresh();
        drain("bp_release", 20);

        // arb_en toggle; credit is 2 on entry
        for (int i = 0; i < 5; i++) q1.push_back(10'(10'h240 + i));
        for (int i = 0; i < 3; i++) q0.push_back(10'(10'h1C0 + i));
        sched("10111010");
        refresh();
        begin
            int npop = 0;
            for (int i = 0; i < 20 && npop < 3; i++) begin
                tick();
                npop += int'(samp0) + int'(samp1);
            end
            check("en_pops_before", npop, 3);
        end
        arb_en = 1'b0;
        #1;
        check("en_off_pops", {pop1, pop0}, 2'b00);
        tick();
        check("en_off_state", arb_state, 2'd1);
        check("en_off_pops2", {pop1, pop0}, 2'b00);
        tick();
        check("en_off_q", {q1.size() == 3, q0.size() == 2}, 2'b11);
        arb_en = 1'b1;
        drain("en_resume", 40);

        // Asynchronous reset while a dest-1 push is registered
        q1 = '{10'h3AB};
        refresh();
        tick();
        tick();
        check("ar_push_before", push, 2'b10);
        #2 reset = 1'b1;
        #1;
        check("ar_push", push, 2'b00);
        check("ar_valid", valid_out, 1'b0);
        check("ar_dataout", dataout, 10'h000);
        check("ar_state", arb_state, 2'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        check("ar_init", arb_state, 2'd0);
        tick();
        check("ar_idle", arb_state, 2'd1);

`ifdef ARB_CLASS_STATS_EN
        check("st_rst0", grant_cnt0, 16'd0);
        check("st_rst1", grant_cnt1, 16'd0);
        for (int i = 0; i < 5; i++) q0.push_back(10'(10'h020 + i));
        for (int i = 0; i < 7; i++) q1.push_back(10'(10'h360 + i));
        sched("111011101000");
        refresh();
        drain("stats", 40);
        check("st_cnt0", grant_cnt0, 16'd5);
        check("st_cnt1", grant_cnt1, 16'd7);
        q0 = '{10'h0EE};
        sched("0");
        refresh();
        tick();
        stats_clr = 1'b1;
        #1;
        check("st_clr_pop", pop0, 1'b1);
        tick();
        stats_clr = 1'b0;
        check("st_clr0", grant_cnt0, 16'd0);
        check("st_clr1", grant_cnt1, 16'd0);
        drain("stats_clr", 10);
`endif

        check("final_scoreboard", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
